// File: rtl/ram_access_arbiter_pkg.sv
// Shared types and constants for the RAM access arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Port indices; the registered winner flag holds one of these.
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Port C wins unless only D asks or D is being forced through.
  function automatic logic pick_port(input logic c_req, input logic d_req,
                                     input logic force_d);
    return (d_req && (!c_req || force_d)) ? PORT_D : PORT_C;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_starve_counter.sv
// Saturating count of arbitrations port D lost while requesting.
// hit is high while the count equals MAX_WAIT.
module ram_arb_starve_counter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

  logic [3:0] count;

  // Clear has priority over increment; the count sticks at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 4'd1;
    end
  end

  assign hit = (count == LIMIT);

endmodule

// File: rtl/ram_access_arbiter.sv
// Two-port arbiter/sequencer for the single-port 256-byte block RAM.
// Port C has fixed priority over port D. Defining RAM_ARB_STARVE_GUARD_EN
// adds a starvation guard that forces D through after MAX_WAIT losses.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              qzt_clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              c_gnt,
  output logic              d_gnt,
  output logic              c_done,
  output logic              d_done,
  output logic [DATA_W-1:0] c_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
    $error("ram_access_arbiter: MAX_WAIT must be in 1..15");
  end

  state_t            state;
  logic              win_port;
  logic              win_we;

  logic              arbitrate;
  logic              pick;
  logic              force_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Arbitration decision and the winner's command fields.
  always_comb begin
    arbitrate = (state == IDLE) && en && (c_req || d_req);
    pick      = pick_port(c_req, d_req, force_d);
    if (pick == PORT_D) begin
      sel_we    = d_we;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end else begin
      sel_we    = c_we;
      sel_addr  = c_addr;
      sel_wdata = c_wdata;
    end
  end

`ifdef RAM_ARB_STARVE_GUARD_EN
  logic starve_inc;
  logic starve_clr;
  logic starve_hit;

  // A loss only counts when D was actually asking.
  always_comb begin
    starve_inc = arbitrate && d_req && (pick == PORT_C);
    starve_clr = arbitrate && (pick == PORT_D);
  end

  ram_arb_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk  (qzt_clk),
    .rst_n(reset_n),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .hit  (starve_hit)
  );

  assign force_d = starve_hit;
`else
  assign force_d = 1'b0;
`endif

  // Access sequencer: IDLE arbitrates, ACCESS strobes the RAM, WAIT
  // covers the read latency and completes the transaction.
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      win_port  <= PORT_C;
      win_we    <= 1'b0;
      c_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      c_done    <= 1'b0;
      d_done    <= 1'b0;
      c_rdata   <= '0;
      d_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      c_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      c_done <= 1'b0;
      d_done <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arbitrate) begin
            win_port  <= pick;
            win_we    <= sel_we;
            ram_en    <= 1'b1;
            ram_we    <= sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            c_gnt     <= (pick == PORT_C);
            d_gnt     <= (pick == PORT_D);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          state <= WAIT;
        end
        WAIT: begin
          if (win_port == PORT_D) begin
            d_done <= 1'b1;
            if (!win_we) d_rdata <= ram_rdata;
          end else begin
            c_done <= 1'b1;
            if (!win_we) c_rdata <= ram_rdata;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
